// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared definitions for the MEM-stage load/store initiator.
//   - size encodings for req_size (11 behaves as a word)
//   - controller state enum
//   - request attribute struct captured at acceptance
//   - misalignment helper used when MEM_ACCESS_ALIGN_CHECK_EN is defined
package mips_mem_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sgn;
  } req_attr_t;

  // Half at an odd byte, or word (incl. size 11) off a word boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    if (size == SZ_BYTE)      return 1'b0;
    else if (size == SZ_HALF) return lo[0];
    else                      return lo != 2'b00;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering, shared by the load and
// read-modify-write store paths.
//   word_i    : memory word (fresh mem_rdata on loads, captured word on RMW)
//   addr_lo_i : byte offset within the word (little-endian lanes)
//   size_i    : SZ_BYTE / SZ_HALF / word
//   signed_i  : sign-extend loaded byte/half
//   wdata_i   : right-justified store data
//   load_o    : extracted and extended load value
//   merge_o   : word_i with the addressed lane(s) replaced by wdata_i
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [NUM_LANES*LANE_W-1:0] word_i,
  input  logic [1:0]                  addr_lo_i,
  input  logic [1:0]                  size_i,
  input  logic                        signed_i,
  input  logic [NUM_LANES*LANE_W-1:0] wdata_i,
  output logic [NUM_LANES*LANE_W-1:0] load_o,
  output logic [NUM_LANES*LANE_W-1:0] merge_o
);

  logic [NUM_LANES-1:0][LANE_W-1:0] word_l, wrep_l, merge_l;
  logic [LANE_W-1:0]                byte_sel;
  logic [2*LANE_W-1:0]              half_sel;

  assign word_l   = word_i;
  assign byte_sel = word_l[addr_lo_i];
  assign half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    load_o = word_i;
    wrep_l = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
        wrep_l = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        load_o = {{16{signed_i & half_sel[15]}}, half_sel};
        wrep_l = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Store data is replicated across lanes; each lane then just picks
  // replicated data or the original byte.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [1:0] KL = 2'(k);
    logic en;
    always_comb begin
      case (size_i)
        SZ_BYTE: en = (addr_lo_i == KL);
        SZ_HALF: en = (addr_lo_i[1] == KL[1]);
        default: en = 1'b1;
      endcase
    end
    assign merge_l[k] = en ? wrep_l[k] : word_l[k];
  end

  assign merge_o = merge_l;

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store initiator for the 16-bit MIPS CPU.
// Accepts byte/half/word requests (valid/ready), converts byte addresses to
// word addresses, does read-modify-write for sub-word stores and returns
// extended load data (valid/ready).
// Ports:
//   clk, reset (sync, active-high)
//   req_valid/req_ready, req_we, req_size, req_signed, req_addr, req_wdata
//   resp_valid/resp_ready, resp_rdata, resp_err
//   mem_addr, mem_wdata, mem_read, mem_write, mem_rdata
// Build option: MEM_ACCESS_ALIGN_CHECK_EN -- when defined, misaligned half or
// word requests skip memory and respond with resp_err=1, resp_rdata=0.
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  req_attr_t         attr_q, attr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              mis;
  logic [DATA_W-1:0] align_word, load_data, merged;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign mis = is_misaligned(req_size, req_addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  // Loads extract straight from the memory bus on the sampling edge; the RMW
  // write merges into the word captured at that edge.
  assign align_word = (state_q == RD) ? mem_rdata : rdata_q;

  mem_lane_align u_align (
    .word_i    (align_word),
    .addr_lo_i (addr_q[1:0]),
    .size_i    (attr_q.size),
    .signed_i  (attr_q.sgn),
    .wdata_i   (wdata_q),
    .load_o    (load_data),
    .merge_o   (merged)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    attr_d       = attr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        attr_d       = '{we: req_we, size: req_size, sgn: req_signed};
        addr_d       = req_addr;
        wdata_d      = req_wdata;
        cnt_d        = '0;
        resp_rdata_d = '0;
        resp_err_d   = mis;
        if (mis)                    state_d = RESP;
        else if (req_we && req_size[1]) state_d = WR;   // whole-word store
        else                        state_d = RD;
      end
      RD: begin
        if (cnt_q == LAT_LAST) begin
          rdata_d = mem_rdata;
          if (attr_q.we) state_d = WR;
          else begin
            resp_rdata_d = load_data;
            state_d      = RESP;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR:   state_d = RESP;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      attr_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      attr_q       <= attr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_read   = (state_q == RD);
  assign mem_write  = (state_q == WR);
  assign mem_addr   = addr_q >> 2;
  // A word store enables every lane, so merged equals the store data.
  assign mem_wdata  = (state_q == WR) ? merged : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk, reset;
  logic        req_valid, req_we, req_signed, resp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  // latency-2 instance
  logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  // latency-3 instance (reset test)
  logic        req_ready_3, resp_valid_3, resp_err_3, mem_read_3, mem_write_3;
  logic [31:0] resp_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;

  logic [31:0] mem [16];
  logic        poke;
  logic [3:0]  poke_a;
  logic [31:0] poke_d;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .MEM_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_3),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_3),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata_3), .resp_err(resp_err_3),
    .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3), .mem_read(mem_read_3),
    .mem_write(mem_write_3), .mem_rdata(mem_rdata_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory model; only the latency-2 instance writes it.
  assign mem_rdata   = mem[mem_addr[3:0]];
  assign mem_rdata_3 = mem[mem_addr_3[3:0]];
  always @(posedge clk) begin
    if (poke)           mem[poke_a] <= poke_d;
    else if (mem_write) mem[mem_addr[3:0]] <= mem_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke_mem(input logic [3:0] a, input logic [31:0] d);
    poke = 1'b1; poke_a = a; poke_d = d;
    step();
    poke = 1'b0;
  endtask

  // Present a request for one cycle; returns at cycle T+1.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] a, input logic [31:0] d);
    req_we = we; req_size = sz; req_signed = sgn; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  // Latency-2 load: response expected at T+3.
  task automatic do_load(input string tag, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] exp);
    do_req(tag, 1'b0, sz, sgn, a, 32'h0);
    step();
    step();
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_rdata"}, resp_rdata, exp);
    chk({tag, "_err"}, 32'(resp_err), 32'd0);
    step();
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    poke = 1'b0; poke_a = '0; poke_d = '0;
    step(); step();

    // reset state
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    poke_mem(4'd1, 32'h0F000003);
    poke_mem(4'd2, 32'hF00F0001);
    poke_mem(4'd3, 32'h11223344);

    // 1: LW 0x4
    do_req("lw4", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    chk("lw4_rd1", 32'(mem_read), 32'd1);
    chk("lw4_addr", mem_addr, 32'd1);
    chk("lw4_valid1", 32'(resp_valid), 32'd0);
    step();
    chk("lw4_rd2", 32'(mem_read), 32'd1);
    step();
    chk("lw4_rd3", 32'(mem_read), 32'd0);
    chk("lw4_valid", 32'(resp_valid), 32'd1);
    chk("lw4_rdata", resp_rdata, 32'h0F000003);
    step();

    // 2: SW 0x0
    do_req("sw0", 1'b1, 2'b10, 1'b0, 32'h0, 32'hF0000001);
    chk("sw0_wr", 32'(mem_write), 32'd1);
    chk("sw0_rd", 32'(mem_read), 32'd0);
    chk("sw0_addr", mem_addr, 32'd0);
    chk("sw0_wdata", mem_wdata, 32'hF0000001);
    step();
    chk("sw0_wr_off", 32'(mem_write), 32'd0);
    chk("sw0_valid", 32'(resp_valid), 32'd1);
    chk("sw0_rdata", resp_rdata, 32'd0);
    step();
    chk("sw0_mem", mem[0], 32'hF0000001);

    // 3: SB 0x9 (RMW), then LW 0x8
    do_req("sb9", 1'b1, 2'b00, 1'b0, 32'h9, 32'h000000AB);
    chk("sb9_rd", 32'(mem_read), 32'd1);
    chk("sb9_raddr", mem_addr, 32'd2);
    step();
    chk("sb9_rd2", 32'(mem_read), 32'd1);
    step();
    chk("sb9_wr", 32'(mem_write), 32'd1);
    chk("sb9_rd_off", 32'(mem_read), 32'd0);
    chk("sb9_waddr", mem_addr, 32'd2);
    chk("sb9_wdata", mem_wdata, 32'hF00FAB01);
    step();
    chk("sb9_valid", 32'(resp_valid), 32'd1);
    chk("sb9_wr_off", 32'(mem_write), 32'd0);
    chk("sb9_rdata", resp_rdata, 32'd0);
    step();
    do_load("lw8", 2'b10, 1'b0, 32'h8, 32'hF00FAB01);

    // 4: sub-word loads of 0xF00F0001
    poke_mem(4'd2, 32'hF00F0001);
    do_load("lb_b", 2'b00, 1'b1, 32'hB, 32'hFFFFFFF0);
    do_load("lbu_b", 2'b00, 1'b0, 32'hB, 32'h000000F0);
    do_load("lb_8", 2'b00, 1'b1, 32'h8, 32'h00000001);
    do_load("lhu_a", 2'b01, 1'b0, 32'hA, 32'h0000F00F);
    do_load("lh_a", 2'b01, 1'b1, 32'hA, 32'hFFFFF00F);
    do_load("lh_8", 2'b01, 1'b1, 32'h8, 32'h00000001);
    do_load("lw_sz3", 2'b11, 1'b0, 32'h8, 32'hF00F0001);

    // SH 0xE into 0x11223344
    do_req("she", 1'b1, 2'b01, 1'b0, 32'hE, 32'h1234BEEF);
    step(); step();
    chk("she_wr", 32'(mem_write), 32'd1);
    chk("she_wdata", mem_wdata, 32'hBEEF3344);
    step(); step();
    do_load("lhu_e", 2'b01, 1'b0, 32'hE, 32'h0000BEEF);

    // 5: response backpressure
    resp_ready = 1'b0;
    do_req("bp", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    step(); step();
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_rdata", resp_rdata, 32'h0F000003);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_strobes", {30'd0, mem_read, mem_write}, 32'd0);
      step();
    end
    resp_ready = 1'b1;
    chk("bp_valid_last", 32'(resp_valid), 32'd1);
    step();
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    chk("bp_idle_valid", 32'(resp_valid), 32'd0);

    // 6: reset during RD cycle 1 of the latency-3 instance
    reset = 1'b1; step(); reset = 1'b0; step();
    chk("rst3_ready_pre", 32'(req_ready_3), 32'd1);
    do_req("rst3", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    chk("rst3_rd1", 32'(mem_read_3), 32'd1);
    reset = 1'b1;
    step();
    chk("rst3_rd_off", 32'(mem_read_3), 32'd0);
    chk("rst3_valid", 32'(resp_valid_3), 32'd0);
    chk("rst3_ready_in_rst", 32'(req_ready_3), 32'd0);
    chk("rst2_rd_off", 32'(mem_read), 32'd0);
    reset = 1'b0;
    step();
    chk("rst3_ready_post", 32'(req_ready_3), 32'd1);
    chk("rst2_ready_post", 32'(req_ready), 32'd1);
    step(); step(); step();
    chk("rst3_no_resp", 32'(resp_valid_3), 32'd0);
    chk("rst3_no_read", 32'(mem_read_3), 32'd0);

    // misaligned LW 0x6
    do_req("mis", 1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    chk("mis_valid", 32'(resp_valid), 32'd1);
    chk("mis_err", 32'(resp_err), 32'd1);
    chk("mis_rdata", resp_rdata, 32'd0);
    chk("mis_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    step();
`else
    chk("mis_rd", 32'(mem_read), 32'd1);
    chk("mis_addr", mem_addr, 32'd1);
    step(); step();
    chk("mis_valid", 32'(resp_valid), 32'd1);
    chk("mis_rdata", resp_rdata, 32'h0F000003);
    chk("mis_err", 32'(resp_err), 32'd0);
    step();
`endif
    chk("end_ready", 32'(req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Load/store initiator for the MEM stage of the 16-bit MIPS CPU. It drives the data_memory port signals mem_addr, mem_wdata, mem_read and mem_write, and captures mem_rdata.
- Accepts byte, half and word requests from the pipeline over a valid/ready handshake.
- Converts byte addresses to the word-addressed memory.
- Performs read-modify-write for sub-word stores.
- Returns extended load data over a valid/ready response handshake.

Parameters:
DATA_W, 32, memory word width; fixed at 32 (four byte lanes).
ADDR_W, 32, request byte-address width.
MEM_LATENCY, 1, cycles mem_read is held before mem_rdata is sampled; legal range 1..15.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept; high only in IDLE and never while reset=1
req_we  in  1  1=store, 0=load
req_size  in  2  SZ_BYTE=00, SZ_HALF=01, SZ_WORD=10; 11 is treated as word
req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-justified
resp_valid  out  1  response available
resp_ready  in  1  consumer takes response
resp_rdata  out  DATA_W  extended load data; 0 for stores
resp_err  out  1  misaligned access (macro-dependent)
mem_addr  out  ADDR_W  word address = req_addr>>2
mem_wdata  out  DATA_W  word to write
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: state=IDLE; all outputs 0 (req_ready=0 while reset=1, then 1 in IDLE).
- Reset mid-operation: the next edge returns to IDLE with strobes cleared; any in-flight request is dropped and no response is produced.
- Capture: on req_valid&&req_ready, the request fields are registered. Byte lanes are little-endian: lane k = bits[8k+7:8k], selected by addr[1:0]; for halves, addr[1] selects the half.
- States:
  - IDLE: accept a request, then go to RD (load or sub-word store), WR (word store), or RESP (error).
  - RD: mem_read=1 and mem_addr held for MEM_LATENCY cycles; mem_rdata is sampled on the last edge. A load then goes to RESP; a sub-word store goes to WR.
  - WR: mem_write=1 for exactly one cycle with the merged or whole word, then go to RESP.
  - RESP: resp_valid=1 with fields stable until resp_ready; when resp_valid&&resp_ready, go to IDLE.
- Latency, with acceptance at cycle T and L=MEM_LATENCY:
  - load: mem_read T+1..T+L, resp_valid from T+L+1.
  - word store: mem_write T+1, resp_valid T+2.
  - sub-word store: mem_read T+1..T+L, mem_write T+L+1, resp_valid T+L+2.
- Strobes: mem_read and mem_write are never high together. Both are 0 in IDLE and RESP.
- Back-to-back: with resp_ready tied high, the next request is accepted the cycle after the response handshake completes. There is no overlap.
- Store merge: only the selected lane(s) are replaced with the low bits of req_wdata; other lanes keep the value read.

Optional Feature:
MEM_ACCESS_ALIGN_CHECK_EN
- Defined: a half at odd addr, or a word with addr[1:0]≠0, performs no memory access and goes IDLE→RESP with resp_err=1 and resp_rdata=0.
- Undefined: resp_err tied 0; alignment bits are ignored (half uses addr[1] only, word ignores addr[1:0]).

Decomposition:
- Package mips_mem_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD, state enum (IDLE, RD, WR, RESP), lane-count constant 4.
- Sub-module mem_lane_align (combinational): extract plus sign/zero-extend for loads; lane merge for stores. It is shared by load and RMW paths.

Test Plan:
1. MEM_LATENCY=2, word1=0x0F000003, LW addr 0x4 -> mem_read high 2 cycles with mem_addr=1; resp_valid at T+3 with resp_rdata=0x0F000003.
2. SW addr 0x0 data 0xF0000001 -> mem_write exactly 1 cycle, mem_addr=0, mem_wdata=0xF0000001, mem_read never high; resp_valid at T+2, resp_rdata=0.
3. word2=0xF00F0001, SB addr 0x9 data 0x000000AB -> read mem_addr=2 then write 0xF00FAB01; a subsequent LW 0x8 returns 0xF00FAB01.
4. word2=0xF00F0001: LB signed addr 0xB -> 0xFFFFFFF0; LHU addr 0xA -> 0x0000F00F; LH signed addr 0xA -> 0xFFFFF00F.
5. Backpressure: hold resp_ready=0 for 3 cycles -> resp_valid and resp_rdata stable, req_ready=0, no strobes; with resp_ready=1, return to IDLE next cycle.
6. Reset asserted in RD cycle 1 (MEM_LATENCY=3) -> next cycle mem_read=0, resp_valid=0, then req_ready=1 after release. Misaligned LW 0x6: with the macro defined, resp_err=1 and no strobes; without it, reads word 1.
